// File: rtl/demux.sv
// Input-side router: serializes a master word into characters, MSB character first, toward the selected decryptor.
// Optional DEMUX_ERR_EN adds a sticky err_o flag for words dropped because select=3.
//
// state   | meaning
// S_IDLE  | no character in flight, ready for a word
// S_SHIFT | emitting character r_cnt of r_word on channel r_sel
module demux #(
  parameter int MST_D_WIDTH = 32,
  parameter int D_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             select,
  input  logic [MST_D_WIDTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [D_WIDTH-1:0]     data0_o,
  output logic                   valid0_o,
  output logic [D_WIDTH-1:0]     data1_o,
  output logic                   valid1_o,
  output logic [D_WIDTH-1:0]     data2_o,
  output logic                   valid2_o
`ifdef DEMUX_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int NCHARS = MST_D_WIDTH / D_WIDTH;
  localparam int CW     = $clog2(NCHARS);
  localparam logic [CW-1:0] LAST = CW'(NCHARS - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [MST_D_WIDTH-1:0] r_word, w_word_nxt;
  logic [1:0]             r_sel, w_sel_nxt;
  logic                   w_last;
  logic                   w_accept;
  logic [D_WIDTH-1:0]     w_char;

  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign ready_o  = rst_n && ((r_state == S_IDLE) || w_last);
  assign w_accept = valid_i && ready_o;
  // The word is shifted left each cycle, so the current character is always the top slice.
  assign w_char   = r_word[MST_D_WIDTH-1 -: D_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_sel_nxt   = r_sel;
    if (r_state == S_SHIFT) begin
      w_word_nxt = r_word << D_WIDTH;
      w_cnt_nxt  = r_cnt + 1'b1;
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    end
    // Acceptance overrides the last-character exit, giving back-to-back words without a bubble.
    if (w_accept) begin
      w_word_nxt  = data_i;
      w_sel_nxt   = select;
      w_cnt_nxt   = '0;
      w_state_nxt = (select == 2'd3) ? S_IDLE : S_SHIFT;
    end
  end

  always_comb begin
    data0_o  = '0;
    valid0_o = 1'b0;
    data1_o  = '0;
    valid1_o = 1'b0;
    data2_o  = '0;
    valid2_o = 1'b0;
    if (r_state == S_SHIFT) begin
      case (r_sel)
        2'd0: begin
          valid0_o = 1'b1;
          data0_o  = w_char;
        end
        2'd1: begin
          valid1_o = 1'b1;
          data1_o  = w_char;
        end
        2'd2: begin
          valid2_o = 1'b1;
          data2_o  = w_char;
        end
        default: ;
      endcase
    end
  end

`ifdef DEMUX_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (select == 2'd3)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: serialization order, back-to-back words, channel routing, drop, reset abort, stall.
module tb_demux;

  logic        clk;
  logic        rst_n;
  logic [1:0]  select;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data0_o, data1_o, data2_o;
  logic        valid0_o, valid1_o, valid2_o;
`ifdef DEMUX_ERR_EN
  logic        err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic exp_err = 1'b0;

  demux #(.MST_D_WIDTH(32), .D_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .select   (select),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .data2_o  (data2_o),
    .valid2_o (valid2_o)
`ifdef DEMUX_ERR_EN
    ,
    .err_o    (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ch = expected active channel (3 = none), d = expected character, rdy = expected ready_o
  task automatic expect_out(input string tag, input int ch, input logic [7:0] d, input logic rdy);
    check({tag, "_v0"}, 32'(valid0_o), 32'(ch == 0));
    check({tag, "_d0"}, 32'(data0_o),  (ch == 0) ? 32'(d) : 32'h0);
    check({tag, "_v1"}, 32'(valid1_o), 32'(ch == 1));
    check({tag, "_d1"}, 32'(data1_o),  (ch == 1) ? 32'(d) : 32'h0);
    check({tag, "_v2"}, 32'(valid2_o), 32'(ch == 2));
    check({tag, "_d2"}, 32'(data2_o),  (ch == 2) ? 32'(d) : 32'h0);
    check({tag, "_rdy"}, 32'(ready_o), 32'(rdy));
`ifdef DEMUX_ERR_EN
    check({tag, "_err"}, 32'(err_o), 32'(exp_err));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w, input logic [1:0] s);
    data_i  = w;
    select  = s;
    valid_i = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    select  = 2'd0;
    data_i  = 32'h0;
    valid_i = 1'b0;
    repeat (3) step();
    expect_out("reset", 3, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    check("idle_rdy", 32'(ready_o), 32'h1);

    // single word on Caesar
    present(32'h41424344, 2'd0);
    step();
    valid_i = 1'b0;
    expect_out("w1_c1", 0, 8'h41, 1'b0);
    step(); expect_out("w1_c2", 0, 8'h42, 1'b0);
    step(); expect_out("w1_c3", 0, 8'h43, 1'b0);
    step(); expect_out("w1_c4", 0, 8'h44, 1'b1);
    step(); expect_out("w1_c5", 3, 8'h00, 1'b1);

    // back-to-back on Scytale, next word held while stalled
    present(32'h01020304, 2'd1);
    step();
    data_i = 32'h05060708;
    expect_out("bb_c1", 1, 8'h01, 1'b0);
    step(); expect_out("bb_c2", 1, 8'h02, 1'b0);
    step(); expect_out("bb_c3", 1, 8'h03, 1'b0);
    step(); expect_out("bb_c4", 1, 8'h04, 1'b1);
    step();
    valid_i = 1'b0;
    expect_out("bb_c5", 1, 8'h05, 1'b0);
    step(); expect_out("bb_c6", 1, 8'h06, 1'b0);
    step(); expect_out("bb_c7", 1, 8'h07, 1'b0);
    step(); expect_out("bb_c8", 1, 8'h08, 1'b1);
    step(); expect_out("bb_c9", 3, 8'h00, 1'b1);

    // ZigZag, select changes after acceptance
    present(32'hAABBCCDD, 2'd2);
    step();
    valid_i = 1'b0;
    select  = 2'd0;
    expect_out("zz_c1", 2, 8'hAA, 1'b0);
    step(); expect_out("zz_c2", 2, 8'hBB, 1'b0);
    step(); expect_out("zz_c3", 2, 8'hCC, 1'b0);
    step(); expect_out("zz_c4", 2, 8'hDD, 1'b1);
    step(); expect_out("zz_c5", 3, 8'h00, 1'b1);

    // select=3 drops words; ready stays high
    present(32'hDEADBEEF, 2'd3);
    step();
    exp_err = 1'b1;
    expect_out("drop_c1", 3, 8'h00, 1'b1);
    step(); expect_out("drop_c2", 3, 8'h00, 1'b1);
    valid_i = 1'b0;
    step(); expect_out("drop_c3", 3, 8'h00, 1'b1);

    // reset in the middle of a word
    present(32'h11223344, 2'd0);
    step();
    valid_i = 1'b0;
    expect_out("rst_c1", 0, 8'h11, 1'b0);
    step();
    expect_out("rst_c2", 0, 8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_rdy_low", 32'(ready_o), 32'h0);
    step();
    exp_err = 1'b0;
    expect_out("rst_c3", 3, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_out("rst_rel", 3, 8'h00, 1'b1);
    step(); expect_out("rst_c5", 3, 8'h00, 1'b1);
    step(); expect_out("rst_c6", 3, 8'h00, 1'b1);

    // valid_i while stalled is ignored
    present(32'h55667788, 2'd1);
    step();
    present(32'h99999999, 2'd0);
    expect_out("stall_c1", 1, 8'h55, 1'b0);
    step(); expect_out("stall_c2", 1, 8'h66, 1'b0);
    step(); expect_out("stall_c3", 1, 8'h77, 1'b0);
    valid_i = 1'b0;
    step(); expect_out("stall_c4", 1, 8'h88, 1'b1);
    step(); expect_out("stall_c5", 3, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux.md
Name: demux

Overview:
- Input-side router for the decryption system; the counterpart of the output mux.
- Accepts one wide ciphertext word from the system master.
- Serializes the word into D_WIDTH characters, most significant character first.
- Delivers the characters, one per clk, on the data/valid interface of the decryptor chosen by select (0 Caesar, 1 Scytale, 2 ZigZag).

Parameters:
- MST_D_WIDTH, 32, master word width; must be an integer multiple of D_WIDTH.
- D_WIDTH, 8, character width toward the decryptors.
- NCHARS is derived, not overridable: MST_D_WIDTH/D_WIDTH. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- select  input  2  destination decryptor; sampled only on word acceptance
- data_i  input  MST_D_WIDTH  ciphertext word from master
- valid_i  input  1  data_i valid
- ready_o  output  1  block can accept a word this cycle
- data0_o  output  D_WIDTH  Caesar character
- valid0_o  output  1  Caesar character valid
- data1_o  output  D_WIDTH  Scytale character
- valid1_o  output  1  Scytale character valid
- data2_o  output  D_WIDTH  ZigZag character
- valid2_o  output  1  ZigZag character valid

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk. All logic on posedge clk.
- Reset values: all dataX_o=0, all validX_o=0, state IDLE, char counter 0, word/select registers 0.
- ready_o is combinational from registers: 1 in IDLE, 1 in SHIFT when counter==NCHARS-1, else 0.
- Not asserted during reset: ready_o is 0 while rst_n=0.
- Acceptance occurs at a clk edge where valid_i=1 and ready_o=1. At that edge the block latches data_i and select.
- States:
  - IDLE: no valid asserted. On acceptance with select in 0..2, go to SHIFT with counter=0.
  - SHIFT: exactly one validX_o=1 (X = latched select) and dataX_o = character[counter].
  - Character 0 = data_i[MST_D_WIDTH-1 -: D_WIDTH]; character k = next lower slice.
  - Counter increments each cycle.
  - At counter==NCHARS-1: if a new word is accepted that same edge, reload and stay in SHIFT with counter=0 (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: character 0 is visible in the cycle after the acceptance edge. Characters are contiguous, with NCHARS valid cycles per word.
- Non-selected channels: data 0, valid 0. Selected channel data is 0 whenever its valid is 0.
- select=3 at acceptance: word is consumed and dropped. No valid is asserted and the block remains or returns to IDLE, with ready_o=1 next cycle.
- select changes after acceptance are ignored until the next acceptance.
- valid_i=1 while ready_o=0: not accepted. The master must hold data_i until ready_o=1.
- Reset mid-word: the word is aborted and all outputs are 0 from the next cycle. Remaining characters are never emitted.

Optional Feature:
- Macro DEMUX_ERR_EN.
- Defined:
  - Extra port err_o, output, 1 bit, reset 0.
  - err_o is sticky and set one cycle after the acceptance of a word with select=3.
  - Cleared only by reset.
  - The word is still dropped as described above.
- Undefined: no err_o port, no error register; select=3 words are silently dropped.

Test Plan:
- Reset, then data_i=0x41424344, select=0, valid_i for 1 cycle -> cycles 1..4 give valid0_o=1 with data0_o=0x41,0x42,0x43,0x44; valid1_o/valid2_o=0; ready_o=0 in cycles 1..3, 1 in cycle 4, IDLE in cycle 5.
- Back-to-back on select=1: 0x01020304 then 0x05060708, valid_i held -> valid1_o high 8 consecutive cycles with data1_o=0x01..0x08, second word accepted at the edge ending cycle 4.
- Word 0xAABBCCDD on select=2; select switches to 0 after acceptance -> all four characters on channel 2 only, data0_o stays 0.
- select=3, data_i=0xDEADBEEF -> no validX_o asserted, ready_o=1 every cycle; with DEMUX_ERR_EN, err_o=1 from the next cycle until reset.
- Assert rst_n=0 in cycle 2 of word 0x11223344 on select=0 -> all outputs 0 the following cycle, 0x33/0x44 never appear, ready_o=1 after reset release.
- valid_i=1 with 0x99999999 while ready_o=0 mid-word -> ignored; only the latched word's characters appear.
